// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM encoding, JEDEC ID bytes.
// Build option SPI_FLASH_RESPONDER_JEDEC_EN enables the 0x9F Read-ID command.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_JEDEC = 8'h9F;

  localparam logic [7:0] JEDEC_MFR  = 8'hEF;
  localparam logic [7:0] JEDEC_TYPE = 8'h40;
  localparam logic [7:0] JEDEC_CAP  = 8'h18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STATUS,
    ST_IGNORE,
    ST_JEDEC
  } state_t;

  function automatic state_t decode_opcode(input logic [7:0] op);
    state_t st;
    st = ST_IGNORE;
    case (op)
      OP_READ:  st = ST_ADDR;
      OP_RDSR:  st = ST_STATUS;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
      OP_JEDEC: st = ST_JEDEC;
`else
      OP_JEDEC: st = ST_IGNORE;
`endif
      default:  st = ST_IGNORE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings SCK/CS/MOSI into clk: 2-FF synchronisers, history register, registered edge pulses.
// Pin-to-pulse latency is 3 clk; mosi_s is delayed to line up with sck_rise.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic sck_meta, sck_sync, sck_hist;
  logic cs_meta, cs_sync, cs_hist;
  logic mosi_meta, mosi_sync;

  // CS resets high so a released reset never fakes a deselect edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_hist  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_hist   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      mosi_s    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_hist  <= sck_sync;
      cs_meta   <= cs_n;
      cs_sync   <= cs_meta;
      cs_hist   <= cs_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      mosi_s    <= mosi_sync;
      sck_rise  <= sck_sync & ~sck_hist;
      sck_fall  <= ~sck_sync & sck_hist;
      cs_fall   <= ~cs_sync & cs_hist;
      cs_rise   <= cs_sync & ~cs_hist;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash target answering READ/RDSR from a synchronous ROM port, all in clk.
// Build option SPI_FLASH_RESPONDER_JEDEC_EN (decoded in spi_flash_pkg) adds Read-ID.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | deselected, MISO idle high, output disabled
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in 24 address bits, then first ROM fetch
// ST_DATA   | streaming ROM bytes, prefetching the next byte on each 8th rise
// ST_STATUS | repeating the status byte
// ST_IGNORE | unsupported opcode, fill bytes out, MOSI discarded
// ST_JEDEC  | manufacturer/type/capacity, then fill bytes
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_W      = 24,
  parameter logic [7:0] STATUS_BYTE = 8'h00,
  parameter logic [7:0] DUMMY_FILL  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_CS,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  output logic              o_MISO_OE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic              o_MEM_RD,
  input  logic [7:0]        i_MEM_DATA,
  output logic              o_BUSY
);

  localparam logic [7:0] STATUS_VAL = {STATUS_BYTE[7:1], 1'b0};

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (i_SPI_CLK),
    .cs_n     (i_SPI_CS),
    .mosi     (i_SPI_MOSI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  state_t            state_q, state_d, op_state;
  logic [4:0]        bit_cnt;
  logic [22:0]       shift_in;
  logic [23:0]       rx_next;
  logic [7:0]        tx_sr;
  logic              miso_q, oe_q, busy_q, rd_q, cap_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        jedec_idx;

  assign rx_next = {shift_in, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    op_state = decode_opcode(rx_next[7:0]);
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_CMD:  if (sck_rise && bit_cnt == 5'd7) state_d = op_state;
        ST_ADDR: if (cap_pend) state_d = ST_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // CS edges take priority over any SCK edge in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q    <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      cap_pend  <= 1'b0;
      addr_q    <= '0;
      tx_sr     <= DUMMY_FILL;
      shift_in  <= '0;
      bit_cnt   <= '0;
      jedec_idx <= '0;
    end else begin
      rd_q     <= 1'b0;
      cap_pend <= 1'b0;
      if (cs_rise) begin
        miso_q  <= 1'b1;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (cs_fall) begin
        oe_q    <= 1'b1;
        busy_q  <= 1'b1;
        bit_cnt <= '0;
        tx_sr   <= DUMMY_FILL;
        miso_q  <= DUMMY_FILL[7];
      end else if (state_q != ST_IDLE) begin
        cap_pend <= rd_q;
        // rotating keeps status/fill bytes repeating without reloads
        if (cap_pend) begin
          tx_sr <= i_MEM_DATA;
        end else if (sck_fall) begin
          miso_q <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], tx_sr[7]};
        end
        if (sck_rise) begin
          shift_in <= rx_next[22:0];
          bit_cnt  <= bit_cnt + 5'd1;
          case (state_q)
            ST_CMD: if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              case (op_state)
                ST_STATUS: tx_sr <= STATUS_VAL;
                ST_JEDEC: begin
                  tx_sr     <= JEDEC_MFR;
                  jedec_idx <= 2'd1;
                end
                default:   tx_sr <= DUMMY_FILL;
              endcase
            end
            ST_ADDR: if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              addr_q  <= rx_next[ADDR_W-1:0];
              rd_q    <= 1'b1;
            end
            ST_DATA: if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              rd_q    <= 1'b1;
            end
            ST_JEDEC: if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              case (jedec_idx)
                2'd1:    tx_sr <= JEDEC_TYPE;
                2'd2:    tx_sr <= JEDEC_CAP;
                default: tx_sr <= DUMMY_FILL;
              endcase
              if (jedec_idx != 2'd3) jedec_idx <= jedec_idx + 2'd1;
            end
            default: bit_cnt <= '0;
          endcase
        end
      end
    end
  end

  assign o_SPI_MISO = miso_q;
  assign o_MISO_OE  = oe_q;
  assign o_BUSY     = busy_q;
  assign o_MEM_ADDR = addr_q;
  assign o_MEM_RD   = rd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised bench for spi_flash_responder: drives mode-0 SPI transfers and compares
// MISO bytes and ROM fetch addresses against a byte-level model of the flash protocol.
module tb_spi_flash_responder;

  localparam logic [23:0] AMASK = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, oe, rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  rom_key = 8'h00;

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_SPI_CLK  (sck),
    .i_SPI_CS   (cs),
    .i_SPI_MOSI (mosi),
    .o_SPI_MISO (miso),
    .o_MISO_OE  (oe),
    .o_MEM_ADDR (mem_addr),
    .o_MEM_RD   (rd),
    .i_MEM_DATA (mem_data),
    .o_BUSY     (busy)
  );

  function automatic logic [7:0] rom_val(input logic [23:0] a);
    return a[7:0] ^ rom_key;
  endfunction

  // synchronous ROM: data valid the cycle after the read strobe
  always @(posedge clk) if (rd) mem_data <= rom_val(mem_addr);

  logic [23:0] rd_log[$];
  always @(negedge clk) if (rd) rd_log.push_back(mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // expected byte k after the opcode for non-read commands
  function automatic logic [7:0] exp_cmd_byte(input logic [7:0] op, input int k);
    if (op == 8'h05) return 8'h00;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
    if (op == 8'h9F) begin
      case (k)
        0: return 8'hEF;
        1: return 8'h40;
        2: return 8'h18;
        default: return 8'hFF;
      endcase
    end
`endif
    return 8'hFF;
  endfunction

  bit   tx_q[$];
  logic rx_q[$];

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b0;
      wait_clk(6);
      sck = 1'b1;
      rx_q.push_back(miso);
      wait_clk(6);
      sck = 1'b0;
    end
  endtask

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = rx_q[8*k+i];
    return b;
  endfunction

  task automatic start_xfer();
    rx_q.delete();
    rd_log.delete();
    cs = 1'b0;
    wait_clk(6);
  endtask

  task automatic end_xfer();
    wait_clk(6);
    cs = 1'b1;
    wait_clk(10);
  endtask

  task automatic run_read(input logic [23:0] addr, input int n, input string tag);
    int nr;
    tx_q.delete();
    push_byte(8'h03);
    push_byte(addr[23:16]);
    push_byte(addr[15:8]);
    push_byte(addr[7:0]);
    for (int i = 0; i < n; i++) push_byte(8'($urandom));
    start_xfer();
    check({tag, "_busy"}, {oe, busy}, 2'b11);
    shift_bits(32 + 8*n);
    end_xfer();
    for (int i = 0; i < 4; i++) check($sformatf("%s_fill%0d", tag, i), rx_byte(i), 8'hFF);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_d%0d", tag, i), rx_byte(4+i), rom_val((addr + 24'(i)) & AMASK));
    nr = rd_log.size();
    check({tag, "_nrd"}, nr, n + 1);
    for (int i = 0; i < n + 1 && i < nr; i++)
      check($sformatf("%s_a%0d", tag, i), rd_log[i], (addr + 24'(i)) & AMASK);
    check({tag, "_idle"}, {oe, busy, miso}, 3'b001);
  endtask

  task automatic run_cmd(input logic [7:0] op, input int n, input string tag);
    tx_q.delete();
    push_byte(op);
    start_xfer();
    shift_bits(8 + 8*n);
    end_xfer();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), rx_byte(1+i), exp_cmd_byte(op, i));
    check({tag, "_nrd"}, rd_log.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, miso, 1'b1);
    check({tag, "_oe"}, oe, 1'b0);
    check({tag, "_addr"}, mem_addr, 24'h0);
    check({tag, "_rd"}, rd, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [23:0] a;

    wait_clk(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    wait_clk(3);

    rom_key = 8'h00;
    run_read(24'h00FFFD, 4, "rd_fffd");

    rom_key = 8'($urandom);
    run_read(24'hFFFFFF, 2, "rd_wrap");

    for (int t = 0; t < 6; t++) begin
      rom_key = 8'($urandom);
      a = 24'($urandom);
      run_read(a, $urandom_range(1, 5), $sformatf("rd_rnd%0d", t));
    end

    run_cmd(8'h05, 2, "rdsr2");
    run_cmd(8'h05, 3, "rdsr3");
    run_cmd(8'h9F, 5, "jedec");
    for (int t = 0; t < 3; t++) begin
      do op = 8'($urandom); while (op == 8'h03 || op == 8'h05 || op == 8'h9F);
      run_cmd(op, 2, $sformatf("ign%0d", t));
    end

    // deselect after 13 address bits
    tx_q.delete();
    push_byte(8'h03);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h10);
    start_xfer();
    shift_bits(8 + 13);
    cs = 1'b1;
    wait_clk(4);
    check("abort_oe", oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_miso", miso, 1'b1);
    wait_clk(10);
    check("abort_nrd", rd_log.size(), 0);
    rom_key = 8'($urandom);
    run_read(24'h000010, 1, "rd_after_abort");

    // reset in the middle of the data phase
    rom_key = 8'($urandom);
    tx_q.delete();
    push_byte(8'h03);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    start_xfer();
    shift_bits(32 + 12);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    wait_clk(3);
    check_reset_vals("arst_hold");
    rst_n = 1'b1;
    wait_clk(2);
    cs = 1'b1;
    wait_clk(10);
    check("post_rst_oe", oe, 1'b0);
    rom_key = 8'($urandom);
    run_read(24'($urandom), 3, "rd_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
